// File: rtl/rv32_exec_mem_unit.sv
// RV32 execute+memory slice: immediate extender, operand-B mux, ALU with {N,Z,C} flags
// and a byte-addressed data memory. Optional alignment trapping via `define MISALIGN_TRAP_EN.
module rv32_exec_mem_unit #(
    parameter int DEPTH = 64
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic [1:0]  ImmControl,
    input  logic        ALUSrc,
    input  logic [2:0]  AluControl,
    input  logic [31:0] SrcA,
    input  logic [31:0] RD2,
    input  logic        WE,
    output logic [31:0] ExtendedImm,
    output logic [31:0] ALUResult,
    output logic [2:0]  Flag,
    output logic [31:0] ReadData,
    output logic        Misaligned
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] src_b;
    logic [31:0] alu_y;
    logic        carry;
    logic [32:0] sum_ext;
    logic [2:0]  funct3;
    logic [AW-1:0] idx;
    logic [31:0] mem [DEPTH];
    logic [31:0] word_rd;
    logic [31:0] wr_word;
    logic        wr_ok;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] rd_sized;
    logic        mis;
    logic        unused_bits;

    always_comb begin
        ExtendedImm = '0;
        case (ImmControl)
            2'b00: ExtendedImm = {{20{Instr[31]}}, Instr[31:20]};
            2'b01: ExtendedImm = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
            2'b10: ExtendedImm = {{20{Instr[31]}}, Instr[7], Instr[30:25], Instr[11:8], 1'b0};
            default: ExtendedImm = {{12{Instr[31]}}, Instr[19:12], Instr[20], Instr[30:21], 1'b0};
        endcase
    end

    assign src_b   = ALUSrc ? ExtendedImm : RD2;
    assign sum_ext = {1'b0, SrcA} + {1'b0, src_b};

    always_comb begin
        alu_y = '0;
        carry = 1'b0;
        case (AluControl)
            3'b000: begin
                alu_y = sum_ext[31:0];
                carry = sum_ext[32];
            end
            3'b001: begin
                alu_y = SrcA - src_b;
                carry = (SrcA >= src_b);
            end
            3'b010: alu_y = SrcA & src_b;
            3'b011: alu_y = SrcA | src_b;
            3'b100: alu_y = SrcA ^ src_b;
            3'b101: alu_y = {31'd0, $signed(SrcA) < $signed(src_b)};
            3'b110: alu_y = SrcA << src_b[4:0];
            default: alu_y = SrcA >> src_b[4:0];
        endcase
    end

    assign ALUResult = alu_y;
    assign Flag      = {alu_y[31], (alu_y == 32'd0), carry};

    assign funct3  = Instr[14:12];
    assign idx     = alu_y[AW+1:2];
    assign word_rd = mem[idx];

`ifdef MISALIGN_TRAP_EN
    assign mis = (((funct3 == 3'b001) || (funct3 == 3'b101)) && alu_y[0])
               || ((funct3 == 3'b010) && (alu_y[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif
    assign Misaligned = mis;

    // Without trapping, half/word lanes simply drop the low address bits.
    assign lane_byte = word_rd[{alu_y[1:0], 3'b000} +: 8];
    assign lane_half = alu_y[1] ? word_rd[31:16] : word_rd[15:0];

    always_comb begin
        rd_sized = word_rd;
        case (funct3)
            3'b000: rd_sized = {{24{lane_byte[7]}}, lane_byte};
            3'b001: rd_sized = {{16{lane_half[15]}}, lane_half};
            3'b100: rd_sized = {24'd0, lane_byte};
            3'b101: rd_sized = {16'd0, lane_half};
            default: rd_sized = word_rd;
        endcase
        if (mis) rd_sized = '0;
    end

    assign ReadData = rd_sized;

    always_comb begin
        wr_word = word_rd;
        wr_ok   = 1'b0;
        case (funct3)
            3'b000: begin
                wr_word[{alu_y[1:0], 3'b000} +: 8] = RD2[7:0];
                wr_ok = 1'b1;
            end
            3'b001: begin
                wr_word[{alu_y[1], 4'b0000} +: 16] = RD2[15:0];
                wr_ok = 1'b1;
            end
            3'b010: begin
                wr_word = RD2;
                wr_ok   = 1'b1;
            end
            default: wr_ok = 1'b0;
        endcase
        if (mis) wr_ok = 1'b0;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (WE && wr_ok) begin
            mem[idx] <= wr_word;
        end
    end

    // Opcode bits and address bits above the memory size are intentionally ignored.
    assign unused_bits = ^{Instr[6:0], alu_y[31:AW+2]};

endmodule

// File: tb/tb_rv32_exec_mem_unit.sv
// Directed bench for rv32_exec_mem_unit: expectations queued per step, drained after settle.
module tb_rv32_exec_mem_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] Instr;
    logic [1:0]  ImmControl;
    logic        ALUSrc;
    logic [2:0]  AluControl;
    logic [31:0] SrcA;
    logic [31:0] RD2;
    logic        WE;
    logic [31:0] ExtendedImm;
    logic [31:0] ALUResult;
    logic [2:0]  Flag;
    logic [31:0] ReadData;
    logic        Misaligned;

    int n_cmp = 0;
    int n_err = 0;

    localparam int S_IMM = 0, S_ALU = 1, S_FLAG = 2, S_RD = 3, S_MIS = 4;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    rv32_exec_mem_unit #(.DEPTH(64)) dut (
        .CLK(CLK), .Reset(Reset), .Instr(Instr), .ImmControl(ImmControl),
        .ALUSrc(ALUSrc), .AluControl(AluControl), .SrcA(SrcA), .RD2(RD2), .WE(WE),
        .ExtendedImm(ExtendedImm), .ALUResult(ALUResult), .Flag(Flag),
        .ReadData(ReadData), .Misaligned(Misaligned)
    );

    always #5 CLK = ~CLK;

    task automatic push(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                S_IMM:   obs = ExtendedImm;
                S_ALU:   obs = ALUResult;
                S_FLAG:  obs = {29'd0, Flag};
                S_RD:    obs = ReadData;
                default: obs = {31'd0, Misaligned};
            endcase
            n_cmp++;
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Memory access at byte address addr with given funct3 (imm field zero).
    task automatic mem_op(input logic [31:0] addr, input logic [2:0] f3);
        Instr      = {17'd0, f3, 12'h003};
        ImmControl = 2'b00;
        ALUSrc     = 1'b1;
        AluControl = 3'b000;
        SrcA       = addr;
    endtask

    task automatic store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] data);
        @(negedge CLK);
        mem_op(addr, f3);
        RD2 = data;
        WE  = 1'b1;
        @(posedge CLK);
        #1;
        WE = 1'b0;
    endtask

    task automatic load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] exp_val);
        @(negedge CLK);
        mem_op(addr, f3);
        push(tag, S_RD, exp_val);
        drain();
    endtask

    task automatic alu(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] ctl, input logic [31:0] exp_y, input logic [2:0] exp_f);
        @(negedge CLK);
        Instr = 32'd0; ImmControl = 2'b00; ALUSrc = 1'b0;
        SrcA = a; RD2 = b; AluControl = ctl;
        push({tag, "_y"}, S_ALU, exp_y);
        push({tag, "_f"}, S_FLAG, {29'd0, exp_f});
        drain();
    endtask

    task automatic imm(input string tag, input logic [31:0] ins, input logic [1:0] ctl,
                       input logic [31:0] exp_v);
        @(negedge CLK);
        Instr = ins; ImmControl = ctl;
        push(tag, S_IMM, exp_v);
        drain();
    endtask

    initial begin
        Reset = 1'b0; Instr = '0; ImmControl = '0; ALUSrc = 1'b0; AluControl = '0;
        SrcA = '0; RD2 = '0; WE = 1'b0;
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b1;

        // Reset clears memory and blocks writes
        store(32'd0,   3'b010, 32'hDEADBEEF);
        store(32'd8,   3'b010, 32'h12345678);
        store(32'd252, 3'b010, 32'hCAFEF00D);
        load("pre_rst_252", 32'd252, 3'b010, 32'hCAFEF00D);
        @(negedge CLK);
        Reset = 1'b0;
        load("rst_0",   32'd0,   3'b010, 32'h0);
        load("rst_8",   32'd8,   3'b010, 32'h0);
        load("rst_252", 32'd252, 3'b010, 32'h0);
        store(32'd8, 3'b010, 32'hFFFFFFFF);
        load("rst_we_ign", 32'd8, 3'b010, 32'h0);
        @(negedge CLK);
        Reset = 1'b1;
        load("post_rst_8", 32'd8, 3'b010, 32'h0);

        // addi-style I immediate through ALU
        @(negedge CLK);
        Instr = 32'h00500093; ImmControl = 2'b00; ALUSrc = 1'b1; AluControl = 3'b000;
        SrcA = 32'd7; RD2 = 32'd99;
        push("addi_imm", S_IMM, 32'd5);
        push("addi_y", S_ALU, 32'd12);
        push("addi_f", S_FLAG, 32'd0);
        drain();

        alu("sub_eq",  32'd5, 32'd5, 3'b001, 32'd0, 3'b011);
        alu("sub_neg", 32'd0, 32'd1, 3'b001, 32'hFFFFFFFF, 3'b100);
        alu("slt",     32'hFFFFFFFF, 32'd1, 3'b101, 32'd1, 3'b000);
        alu("add_cy",  32'hFFFFFFFF, 32'd1, 3'b000, 32'd0, 3'b011);
        alu("and",     32'hF0F0_FF00, 32'h0FF0_F0F0, 3'b010, 32'h00F0_F000, 3'b000);
        alu("or",      32'hF000_0000, 32'h0000_000F, 3'b011, 32'hF000_000F, 3'b100);
        alu("xor",     32'hAAAA_AAAA, 32'hAAAA_AAAA, 3'b100, 32'd0, 3'b010);
        alu("sll",     32'd1, 32'h21, 3'b110, 32'd2, 3'b000);
        alu("srl",     32'h8000_0000, 32'd31, 3'b111, 32'd1, 3'b000);

        imm("imm_s", 32'hFE000FA3, 2'b01, 32'hFFFFFFFF);
        imm("imm_b", 32'hFE000EE3, 2'b10, 32'hFFFFFFFC);
        imm("imm_j", 32'h800000EF, 2'b11, 32'hFFF00000);

        // Sized loads
        store(32'd8, 3'b010, 32'h80FF1234);
        load("lb_11",  32'd11, 3'b000, 32'hFFFFFF80);
        load("lbu_11", 32'd11, 3'b100, 32'h00000080);
        load("lh_10",  32'd10, 3'b001, 32'hFFFF80FF);
        load("lhu_8",  32'd8,  3'b101, 32'h00001234);
        load("lb_8",   32'd8,  3'b000, 32'h00000034);

        // Partial stores
        store(32'd9, 3'b000, 32'h000000AB);
        load("sb_9", 32'd8, 3'b010, 32'h80FFAB34);
        store(32'd10, 3'b001, 32'h00005555);
        load("sh_10", 32'd8, 3'b010, 32'h5555AB34);
        store(32'd8, 3'b011, 32'h11111111);
        load("st_f3_011", 32'd8, 3'b010, 32'h5555AB34);
        load("wrap_264", 32'd264, 3'b010, 32'h5555AB34);

        // Alignment behaviour
        store(32'd4, 3'b010, 32'h11223344);
`ifdef MISALIGN_TRAP_EN
        @(negedge CLK);
        mem_op(32'd6, 3'b010);
        push("mis_sw6", S_MIS, 32'd1);
        push("mis_lw6", S_RD, 32'd0);
        drain();
        store(32'd6, 3'b010, 32'hA5A5A5A5);
        load("mis_keep4", 32'd4, 3'b010, 32'h11223344);
        @(negedge CLK);
        mem_op(32'd5, 3'b101);
        push("mis_lhu5", S_MIS, 32'd1);
        drain();
`else
        @(negedge CLK);
        mem_op(32'd6, 3'b010);
        push("nomis_flag", S_MIS, 32'd0);
        push("lw_6", S_RD, 32'h11223344);
        drain();
        load("lhu_7", 32'd7, 3'b101, 32'h00001122);
        store(32'd6, 3'b010, 32'hA5A5A5A5);
        load("sw6_to4", 32'd4, 3'b010, 32'hA5A5A5A5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
